// File: rtl/seg_serial_drv.sv
// Serial driver for daisy-chained 7-segment shift registers: decode, shift MSB-first, latch with EN.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
`timescale 1ns/1ps
module seg_serial_drv #(
    parameter int NUM_DIGITS     = 8,
    parameter int DIV_LOG2       = 1,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic [NUM_DIGITS*4-1:0] num,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    update,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    s_clk,
    output logic                    s_clrn,
    output logic                    sout,
    output logic                    EN
);
    localparam int FRAME = NUM_DIGITS * 8;
    localparam int HALF  = 1 << DIV_LOG2;
    localparam int CW    = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;
    localparam int BW    = $clog2(FRAME);
    localparam int RW    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [CW-1:0] H_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] H_PRE  = CW'((HALF > 1) ? HALF - 2 : 0);
    localparam logic [BW-1:0] B_LAST = BW'(FRAME - 1);
    localparam logic [RW-1:0] R_LAST = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, LATCH} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bcnt;
    logic [RW-1:0]    rcnt;
    logic             ph;
    logic             pending;
    logic             refresh_hit;
    logic             start;
    logic [FRAME-1:0] frame_d;
    logic [FRAME-1:0] sreg;

    // Active-low {g,f,e,d,c,b,a}; the dp bit is added by the caller.
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    // Digit NUM_DIGITS-1 lands in the top byte so it leaves the shifter first.
    always_comb begin
        logic [3:0] nib;
        logic [7:0] byte_v;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        logic       lead;
        lead = 1'b1;
`endif
        frame_d = '0;
        nib     = '0;
        byte_v  = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            nib    = num[d*4 +: 4];
            byte_v = {~dp_mask[d], hex_seg(nib)};
            if (blank_mask[d])
                byte_v = 8'hFF;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (nib != 4'h0)
                lead = 1'b0;
            if (lead && d != 0)
                byte_v = 8'hFF;
`endif
            frame_d[d*8 +: 8] = byte_v;
        end
    end

    assign refresh_hit = (REFRESH_CYCLES > 0) && (rcnt == R_LAST);
    assign start       = update | pending | refresh_hit;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            s_clk      <= 1'b1;
            s_clrn     <= 1'b1;
            sout       <= 1'b0;
            EN         <= 1'b0;
            pending    <= 1'b0;
            rcnt       <= '0;
            cnt        <= '0;
            bcnt       <= '0;
            ph         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state != IDLE && update)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLR;
                        busy    <= 1'b1;
                        s_clrn  <= 1'b0;
                        cnt     <= '0;
                        pending <= 1'b0;
                        rcnt    <= '0;
                    end else if (REFRESH_CYCLES > 0) begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                CLR: begin
                    if (cnt == H_LAST) begin
                        cnt    <= '0;
                        s_clrn <= 1'b1;
                        s_clk  <= 1'b0;
                        sout   <= sreg[FRAME-1];
                        ph     <= 1'b0;
                        bcnt   <= '0;
                        state  <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == H_LAST) begin
                        cnt <= '0;
                        if (!ph) begin
                            s_clk <= 1'b1;
                            ph    <= 1'b1;
                        end else if (bcnt == B_LAST) begin
                            // s_clk stays high and sout holds the last bit through the latch
                            state      <= LATCH;
                            EN         <= 1'b1;
                            frame_done <= (HALF == 1);
                        end else begin
                            s_clk <= 1'b0;
                            sout  <= sreg[FRAME-2];
                            ph    <= 1'b0;
                            bcnt  <= bcnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == H_LAST) begin
                        cnt   <= '0;
                        EN    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        frame_done <= (HALF > 1) && (cnt == H_PRE);
                    end
                end
            endcase
        end
    end

    // Frame data register: loaded at frame start, shifted at the end of each high phase.
    always_ff @(posedge clk) begin
        if (state == IDLE && start)
            sreg <= frame_d;
        else if (state == SHIFT && cnt == H_LAST && ph)
            sreg <= {sreg[FRAME-2:0], 1'b0};
    end
endmodule

// File: tb/tb_seg_serial_drv.sv
// Scoreboard bench for seg_serial_drv: expected frames are queued at update time and
// compared by a monitor that reassembles bits on s_clk rising edges.
`timescale 1ns/1ps
module tb_seg_serial_drv;
    localparam int HALF  = 2;
    localparam int FRAME = 64;
    localparam int FLEN  = HALF * (2 * FRAME + 2);

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        update = 1'b0;
    logic [31:0] num = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  blank_mask = '0;
    logic        busy, frame_done, s_clk, s_clrn, sout, EN;

    logic        update2 = 1'b0;
    logic [7:0]  num2 = 8'h3C;
    logic [1:0]  dp2 = 2'b01;
    logic [1:0]  bl2 = 2'b00;
    logic        busy2, frame_done2, s_clk2, s_clrn2, sout2, en2;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    seg_serial_drv #(.NUM_DIGITS(8), .DIV_LOG2(1), .REFRESH_CYCLES(0)) dut (
        .clk(clk), .clrn(clrn), .num(num), .dp_mask(dp_mask), .blank_mask(blank_mask),
        .update(update), .busy(busy), .frame_done(frame_done), .s_clk(s_clk),
        .s_clrn(s_clrn), .sout(sout), .EN(EN)
    );

    seg_serial_drv #(.NUM_DIGITS(2), .DIV_LOG2(0), .REFRESH_CYCLES(10)) dut_rf (
        .clk(clk), .clrn(clrn), .num(num2), .dp_mask(dp2), .blank_mask(bl2),
        .update(update2), .busy(busy2), .frame_done(frame_done2), .s_clk(s_clk2),
        .s_clrn(s_clrn2), .sout(sout2), .EN(en2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected frame, first-transmitted byte in the top 8 bits.
    function automatic logic [63:0] model_frame(input logic [31:0] n, input logic [7:0] dp,
                                                input logic [7:0] bl);
        logic [7:0]  lut [16];
        logic [7:0]  b;
        logic [63:0] f;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        bit          lead;
        lead = 1'b1;
`endif
        lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        f = '0;
        for (int d = 7; d >= 0; d--) begin
            b    = lut[n[d*4 +: 4]];
            b[7] = ~dp[d];
            if (bl[d]) b = 8'hFF;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (n[d*4 +: 4] != 4'h0) lead = 1'b0;
            if (lead && d != 0) b = 8'hFF;
`endif
            f = {f[55:0], b};
        end
        return f;
    endfunction

    // Monitor for the main instance
    logic [63:0] cap = '0;
    int          nbits = 0, en_cnt = 0, busy_cnt = 0;
    logic        prev_sclk = 1'b1;
    always @(negedge clk) begin
        if (!clrn) begin
            nbits = 0; en_cnt = 0; busy_cnt = 0; prev_sclk = 1'b1;
        end else begin
            if (busy && s_clk && !prev_sclk) begin
                cap = {cap[62:0], sout};
                nbits++;
            end
            prev_sclk = s_clk;
            if (EN) en_cnt++;
            if (busy) busy_cnt++; else busy_cnt = 0;
            if (frame_done) begin
                chk("frame_bits", 64'(nbits), 64'(FRAME));
                chk("en_len", 64'(en_cnt), 64'(HALF));
                chk("frame_len", 64'(busy_cnt), 64'(FLEN));
                if (exp_q.size() == 0) chk("unexpected_frame", cap, 64'hx);
                else chk("frame_data", cap, exp_q.pop_front());
                nbits = 0; en_cnt = 0;
            end
        end
    end

    // Monitor for the auto-refresh instance: 10 idle cycles, then a 34-cycle frame
    int   run_lo = 0, run_hi = 0;
    logic prev_b2 = 1'b0;
    always @(negedge clk) begin
        if (!clrn) begin
            run_lo = 0; run_hi = 0; prev_b2 = 1'b0;
        end else begin
            if (busy2) begin
                if (!prev_b2) begin
                    chk("refresh_gap", 64'(run_lo), 64'd10);
                    run_hi = 0;
                end
                run_hi++;
            end else begin
                if (prev_b2) begin
                    chk("refresh_frame_len", 64'(run_hi), 64'd34);
                    run_lo = 0;
                end
                run_lo++;
            end
            prev_b2 = busy2;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [63:0] exp);
        exp_q.push_back(exp);
        update = 1'b1;
        tick(1);
        update = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (frame_done !== 1'b1 && n < 2000) begin
            tick(1);
            n++;
        end
        chk(name, 64'(n < 2000), 64'd1);
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick(1);
        update = 1'b0;
    endtask

    initial begin
        logic act;
        tick(3);
        chk("rst_s_clk", 64'(s_clk), 64'd1);
        chk("rst_en", 64'(EN), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sout", 64'(sout), 64'd0);
        chk("rst_s_clrn", 64'(s_clrn), 64'd1);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        clrn = 1'b1;
        act = 1'b0;
        repeat (100) begin
            tick(1);
            if (busy || EN || !s_clk || frame_done) act = 1'b1;
        end
        chk("idle_quiet", 64'(act), 64'd0);

        num = 32'h12345678; dp_mask = 8'h00; blank_mask = 8'h00;
        start_frame(64'hF9A4B0999282F880);
        chk("busy_after_update", 64'(busy), 64'd1);
        wait_done("t2_done");
        tick(1);
        chk("busy_cleared", 64'(busy), 64'd0);

        num = 32'h0000000F; dp_mask = 8'h01; blank_mask = 8'h80;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        start_frame(64'hFFFFFFFFFFFFFF0E);
`else
        start_frame(64'hFFC0C0C0C0C0C00E);
`endif
        wait_done("t3_done");
        tick(2);

        // Two merged re-requests plus a mid-frame input change
        num = 32'h13579BDF; dp_mask = 8'h5A; blank_mask = 8'h00;
        start_frame(model_frame(num, dp_mask, blank_mask));
        tick(49);
        pulse_update();
        tick(48);
        pulse_update();
        tick(19);
        num = 32'hAAAAAAAA; dp_mask = 8'h00; blank_mask = 8'h00;
        exp_q.push_back(64'h8888888888888888);
        wait_done("t4_first");
        tick(1);
        chk("t4_idle_gap", 64'(busy), 64'd0);
        tick(1);
        chk("t4_followup", 64'(busy), 64'd1);
        wait_done("t4_second");
        tick(1);
        act = 1'b0;
        repeat (20) begin
            tick(1);
            if (busy) act = 1'b1;
        end
        chk("t4_no_third", 64'(act), 64'd0);

        // Reset during shift bit 40 with a pending request outstanding
        num = 32'h2468ACE0;
        start_frame(model_frame(num, dp_mask, blank_mask));
        tick(99);
        pulse_update();
        tick(62);
        clrn = 1'b0;
        tick(1);
        exp_q.delete();
        chk("abort_s_clk", 64'(s_clk), 64'd1);
        chk("abort_sout", 64'(sout), 64'd0);
        chk("abort_en", 64'(EN), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_s_clrn", 64'(s_clrn), 64'd1);
        clrn = 1'b1;
        act = 1'b0;
        repeat (300) begin
            tick(1);
            if (busy || EN || frame_done) act = 1'b1;
        end
        chk("abort_stays_idle", 64'(act), 64'd0);

        num = 32'h000000A0; dp_mask = 8'h00; blank_mask = 8'h00;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        start_frame(64'hFFFFFFFFFFFF88C0);
`else
        start_frame(64'hC0C0C0C0C0C088C0);
`endif
        wait_done("t6_done");
        tick(1);

        for (int i = 0; i < 8; i++) begin
            num        = $urandom >> (4 * $urandom_range(0, 7));
            dp_mask    = 8'($urandom);
            blank_mask = 8'($urandom & $urandom);
            start_frame(model_frame(num, dp_mask, blank_mask));
            tick($urandom_range(5, 200));
            num        = $urandom;
            dp_mask    = 8'($urandom);
            blank_mask = 8'($urandom);
            wait_done("rand_done");
            tick($urandom_range(1, 5));
        end

        tick(5);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/seg_serial_drv.md
Name: seg_serial_drv

Overview:
Parametrised serial driver for N-digit 7-segment displays fed by external daisy-chained shift registers (s_clk/sout/s_clrn/EN).
- Decodes hex nibbles to active-low segment bytes and shifts the frame MSB-first at a divided rate.
- Strobes EN to latch the frame.
- Adds an update handshake, one-deep pending request, per-digit dp/blank masks and optional auto-refresh.
- Sits between the CPU seg MMIO register (seg_wdata) and the board pins.

Parameters:
NUM_DIGITS, 8, number of digits; FRAME = NUM_DIGITS*8 bits
DIV_LOG2, 1, half-period of s_clk is HALF = 2^DIV_LOG2 clk cycles (DIV_LOG2 >= 0)
REFRESH_CYCLES, 0, idle cycles before an automatic frame; 0 disables auto-refresh

Ports:
clk  input  1  system clock
clrn  input  1  synchronous active-low reset
num  input  NUM_DIGITS*4  hex value; nibble i drives digit i, digit NUM_DIGITS-1 is leftmost
dp_mask  input  NUM_DIGITS  1 lights the decimal point of digit i
blank_mask  input  NUM_DIGITS  1 forces digit i dark (byte 8'hFF)
update  input  1  request a frame with current num/dp_mask/blank_mask
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse on the last cycle of the LATCH state
s_clk  output  1  serial clock to shift registers; idles high
s_clrn  output  1  active-low clear to shift registers
sout  output  1  serial data
EN  output  1  latch/output-enable strobe

Behaviour:
Interface:
- One clock (clk).
- Reset clrn is synchronous, active-low, sampled on the rising edge of clk.

Reset values:
- s_clk=1, s_clrn=1, sout=0, EN=0, busy=0, frame_done=0.
- State IDLE; pending=0; refresh counter=0.

Segment byte per digit: {dp,g,f,e,d,c,b,a}, active-low.
- Hex 0..F maps to C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
- dp bit 7 = ~dp_mask[i].
- blank_mask[i]=1 forces FF, overriding dp.
- The frame is digit NUM_DIGITS-1 first; within a byte, bit 7 goes first.

FSM:
- IDLE: busy=0. On update=1, or refresh counter hitting REFRESH_CYCLES-1 (when REFRESH_CYCLES>0):
  - capture the decoded frame into the shift register;
  - go CLR;
  - busy=1 from the next cycle.
- CLR: s_clrn=0 for HALF cycles, then s_clrn=1 and go SHIFT.
- SHIFT, per bit:
  - first HALF cycles: s_clk=0 with sout=current MSB;
  - next HALF cycles: s_clk=1, the rising edge falls mid-bit;
  - at the end of the high phase, shift left by 1.
  - After FRAME bits, go LATCH with s_clk=1 and sout held at the last bit.
- LATCH: EN=1 for HALF cycles; frame_done pulses on the final cycle; go IDLE.
- Frame duration: HALF*(2*FRAME+2) cycles from the first CLR cycle.

Boundary conditions:
- update while busy: set pending (one-deep; further updates merge). Inputs are not sampled at that time.
  - On LATCH exit with pending=1: clear pending, enter IDLE for exactly one cycle, then start a new frame sampling inputs in that IDLE cycle.
- update in the same cycle as a refresh hit: a single frame starts.
- Refresh counter: counts only in IDLE; cleared on every frame start; saturating logic is unnecessary because a hit always starts a frame.
- Inputs are sampled only at frame start. Changes mid-frame do not corrupt the current frame.
- clrn=0 mid-frame: every output returns to its reset value on the next edge and pending is dropped. No partial EN is ever produced.
- DIV_LOG2=0: HALF=1, so s_clk toggles every cycle.

Optional Feature:
SEG_LEADING_ZERO_BLANK_EN:
- Defined: a digit whose nibble is 0 and all of whose more-significant digits are also 0 emits FF. This overrides its dp_mask bit, since the byte is FF. Digit 0 is never suppressed.
- Undefined: zeros display as C0 (or 40 with dp) as normal. No extra logic is generated.

Test Plan:
1. Reset: clrn=0 for 3 cycles, then 1 -> s_clk=1, EN=0, busy=0, sout=0. No activity for 100 cycles with REFRESH_CYCLES=0.
2. NUM_DIGITS=8, DIV_LOG2=1: num=32'h12345678, masks 0, update pulse -> busy=1 next cycle.
   - Bytes captured on s_clk rising edges are F9,A4,B0,99,92,82,F8,80.
   - EN high for 2 cycles; frame_done 260 cycles after frame start.
3. dp_mask=8'h01, blank_mask=8'h80, num=32'h0000000F -> bytes FF,C0,C0,C0,C0,C0,C0,0E.
4. update re-asserted at cycle 50 of a frame and again at cycle 100, with num changed to 32'hAAAAAAAA at cycle 120 -> exactly one follow-up frame, all bytes 88, starting 1 cycle after frame_done.
5. clrn=0 during SHIFT bit 40 -> outputs reset next edge; no EN pulse; after release busy stays 0 until the next update.
6. REFRESH_CYCLES=10, no update -> frames start every 10 idle cycles. With SEG_LEADING_ZERO_BLANK_EN and num=32'h000000A0 -> bytes FF×6, 88, C0.
